et_tx_err_encoder: RTL

Serial transmitter for the ET error-report line: captures the TLK error vector and the Daisy Chain (DC) error vector and shifts both onto a single-bit line as two headered frames. It is the sending end of the ET error decoder link. The decoder accepts one TLK frame and one DC frame per live period, keyed on a 3-bit header and LSB-first payload.

---
 rtl/et_tx_err_encoder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/et_tx_err_encoder.sv
// ET error-report serial transmitter: sends a headered TLK frame, an idle gap,
// then a headered DC frame, once per live period, from vectors latched at start.
module et_tx_err_encoder #(
  parameter int unsigned LENGTH_ET_TLK_ERR = 232,
  parameter int unsigned LENGTH_ET_DC_ERR  = 232,
  parameter int unsigned GAP_CYCLES        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_live,
  input  logic                         in_send,
  input  logic [LENGTH_ET_TLK_ERR-1:0] in_tlk_err,
  input  logic [LENGTH_ET_DC_ERR-1:0]  in_dc_err,
  output logic                         out_err,
  output logic                         out_busy,
  output logic                         out_done,
  output logic                         out_sent
);

  localparam logic [8:0] HDR_LAST = 9'd2;
  localparam logic [8:0] TLK_LAST = 9'(LENGTH_ET_TLK_ERR - 1);
  localparam logic [8:0] DC_LAST  = 9'(LENGTH_ET_DC_ERR - 1);
  localparam logic [8:0] GAP_LAST = 9'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TLK_HDR,
    S_TLK_DATA,
    S_GAP,
    S_DC_HDR,
    S_DC_DATA,
    S_DONE
  } state_t;

  state_t                       state, state_nx;
  logic [8:0]                   cnt, cnt_nx;
  logic [LENGTH_ET_TLK_ERR-1:0] tlk_q;
  logic [LENGTH_ET_DC_ERR-1:0]  dc_q;
  logic                         start;
  logic                         tlk_bit, dc_bit, err_nx;

  assign start = (state == S_IDLE) && in_send && in_live && !out_sent;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 9'd1;
    unique case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (start) state_nx = S_TLK_HDR;
      end
      S_TLK_HDR:  if (cnt == HDR_LAST) begin state_nx = S_TLK_DATA; cnt_nx = '0; end
      S_TLK_DATA: if (cnt == TLK_LAST) begin state_nx = S_GAP;      cnt_nx = '0; end
      S_GAP:      if (cnt == GAP_LAST) begin state_nx = S_DC_HDR;   cnt_nx = '0; end
      S_DC_HDR:   if (cnt == HDR_LAST) begin state_nx = S_DC_DATA;  cnt_nx = '0; end
      S_DC_DATA:  if (cnt == DC_LAST)  begin state_nx = S_DONE;     cnt_nx = '0; end
      S_DONE: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
    if (!in_live) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
    end
  end

  // Outputs are registered, so the line value is derived from the next state/count.
  always_comb begin
    tlk_bit = 1'b0;
    for (int unsigned i = 0; i < LENGTH_ET_TLK_ERR; i++)
      if (cnt_nx == 9'(i)) tlk_bit = tlk_q[i];
  end

  always_comb begin
    dc_bit = 1'b0;
    for (int unsigned i = 0; i < LENGTH_ET_DC_ERR; i++)
      if (cnt_nx == 9'(i)) dc_bit = dc_q[i];
  end

  always_comb begin
    err_nx = 1'b0;
    unique case (state_nx)
      S_TLK_HDR:  err_nx = (cnt_nx == 9'd0);
      S_TLK_DATA: err_nx = tlk_bit;
      S_DC_HDR:   err_nx = (cnt_nx != 9'd1);
      S_DC_DATA:  err_nx = dc_bit;
      default:    err_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      tlk_q    <= '0;
      dc_q     <= '0;
      out_err  <= 1'b0;
      out_busy <= 1'b0;
      out_done <= 1'b0;
      out_sent <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      out_err  <= err_nx;
      out_busy <= (state_nx != S_IDLE);
      out_done <= (state_nx == S_DONE);
      if (!in_live)                out_sent <= 1'b0;
      else if (state_nx == S_DONE) out_sent <= 1'b1;
      if (start) begin
        tlk_q <= in_tlk_err;
        dc_q  <= in_dc_err;
      end
    end
  end

endmodule
